// File: rtl/pusch_re_map_scheduler_if.sv
`default_nettype none
// ============================================================================
// pusch_re_map_scheduler_if: slot config, readiness and grid-steering bundle.
// Revision 1.0
// ============================================================================
interface pusch_re_map_scheduler_if #(
  parameter int SC_W = 11
);
  logic            start_i;
  logic [3:0]      n_symbol_i;
  logic [6:0]      n_rb_i;
  logic [10:0]     n_sc_i;
  logic            data_avail_i;
  logic            dmrs_ready_i;
  logic            ifft_ready_i;

  logic            data_rd_en_o;
  logic            dmrs_rd_en_o;
  logic [1:0]      sel_o;
  logic            grid_valid_o;
  logic [SC_W-1:0] sc_idx_o;
  logic [3:0]      sym_idx_o;
  logic            sym_done_o;
  logic            slot_done_o;
  logic            cfg_err_o;
  logic            busy_o;

  modport master (
    output start_i, n_symbol_i, n_rb_i, n_sc_i, data_avail_i, dmrs_ready_i, ifft_ready_i,
    input  data_rd_en_o, dmrs_rd_en_o, sel_o, grid_valid_o, sc_idx_o, sym_idx_o,
           sym_done_o, slot_done_o, cfg_err_o, busy_o
  );

  modport slave (
    input  start_i, n_symbol_i, n_rb_i, n_sc_i, data_avail_i, dmrs_ready_i, ifft_ready_i,
    output data_rd_en_o, dmrs_rd_en_o, sel_o, grid_valid_o, sc_idx_o, sym_idx_o,
           sym_done_o, slot_done_o, cfg_err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/pusch_re_map_scheduler.sv
`default_nettype none
// ============================================================================
// pusch_re_map_scheduler: walks the IFFT grid per PUSCH symbol, steering data/DMRS/zero.
// Revision 1.0
// ============================================================================
module pusch_re_map_scheduler #(
  parameter int NFFT     = 2048,
  parameter int SC_W     = 11,
  parameter int DMRS_SYM = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pusch_re_map_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0]      C_SEL_ZERO = 2'd0;
  localparam logic [1:0]      C_SEL_DATA = 2'd1;
  localparam logic [1:0]      C_SEL_DMRS = 2'd2;
  localparam logic [SC_W-1:0] C_SC_LAST  = SC_W'(NFFT - 1);
  localparam logic [12:0]     C_NFFT     = 13'(NFFT);
  localparam logic [3:0]      C_DMRS_SYM = 4'(DMRS_SYM);

  state_t          state_q;
  logic [3:0]      n_symbol_q;
  logic [10:0]     n_sc_q;
  logic [11:0]     band_hi_q;
  logic [SC_W-1:0] sc_idx_q;
  logic [3:0]      sym_idx_q;
  logic            busy_q;
  logic            grid_valid_q;
  logic            data_rd_en_q;
  logic            dmrs_rd_en_q;
  logic [1:0]      sel_q;
  logic            sym_done_q;
  logic            slot_done_q;
  logic            cfg_err_q;

  logic [10:0]     alloc_len_w;
  logic [11:0]     band_hi_w;
  logic            cfg_bad_w;
  logic            is_dmrs_w;
  logic            src_ready_w;
  logic            last_sym_w;
  logic [SC_W-1:0] sc_idx_d;
  logic [11:0]     sc_ext_w;
  logic            in_band_w;
  logic [1:0]      sel_w;
  logic            data_rd_w;
  logic            dmrs_rd_w;
  logic            sym_done_w;

  // 12*N_rb as 8*N_rb + 4*N_rb; the band upper bound needs the extra bit.
  always_comb begin
    alloc_len_w = 11'({bus.n_rb_i, 3'b000}) + 11'({bus.n_rb_i, 2'b00});
    band_hi_w   = {1'b0, bus.n_sc_i} + {1'b0, alloc_len_w};
    cfg_bad_w   = (bus.n_symbol_i == 4'd0) || (bus.n_rb_i == 7'd0) ||
                  ({1'b0, band_hi_w} > C_NFFT);
    is_dmrs_w   = (sym_idx_q == C_DMRS_SYM);
    src_ready_w = bus.ifft_ready_i && (is_dmrs_w ? bus.dmrs_ready_i : bus.data_avail_i);
    last_sym_w  = (sym_idx_q == (n_symbol_q - 4'd1));
    sc_idx_d    = (state_q == S_MAP) ? (sc_idx_q + SC_W'(1)) : '0;
    sc_ext_w    = 12'(sc_idx_d);
    in_band_w   = (sc_ext_w >= {1'b0, n_sc_q}) && (sc_ext_w < band_hi_q);
    sel_w       = !in_band_w ? C_SEL_ZERO : (is_dmrs_w ? C_SEL_DMRS : C_SEL_DATA);
    data_rd_w   = in_band_w && !is_dmrs_w;
    dmrs_rd_w   = in_band_w && is_dmrs_w;
    sym_done_w  = (sc_idx_d == C_SC_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_symbol_q   <= '0;
      n_sc_q       <= '0;
      band_hi_q    <= '0;
      sc_idx_q     <= '0;
      sym_idx_q    <= '0;
      busy_q       <= 1'b0;
      grid_valid_q <= 1'b0;
      data_rd_en_q <= 1'b0;
      dmrs_rd_en_q <= 1'b0;
      sel_q        <= C_SEL_ZERO;
      sym_done_q   <= 1'b0;
      slot_done_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      grid_valid_q <= 1'b0;
      data_rd_en_q <= 1'b0;
      dmrs_rd_en_q <= 1'b0;
      sel_q        <= C_SEL_ZERO;
      sym_done_q   <= 1'b0;
      slot_done_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            n_symbol_q <= bus.n_symbol_i;
            n_sc_q     <= bus.n_sc_i;
            band_hi_q  <= band_hi_w;
            if (cfg_bad_w) begin
              cfg_err_q <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              sym_idx_q <= '0;
              state_q   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (src_ready_w) begin
            state_q      <= S_MAP;
            sc_idx_q     <= sc_idx_d;
            grid_valid_q <= 1'b1;
            sel_q        <= sel_w;
            data_rd_en_q <= data_rd_w;
            dmrs_rd_en_q <= dmrs_rd_w;
            sym_done_q   <= sym_done_w;
          end
        end
        S_MAP: begin
          // Readiness is only consulted in WAIT, so a symbol always runs to completion.
          if (sc_idx_q == C_SC_LAST) begin
            if (last_sym_w) begin
              state_q     <= S_DONE;
              slot_done_q <= 1'b1;
            end else begin
              sym_idx_q <= sym_idx_q + 4'd1;
              state_q   <= S_WAIT;
            end
          end else begin
            sc_idx_q     <= sc_idx_d;
            grid_valid_q <= 1'b1;
            sel_q        <= sel_w;
            data_rd_en_q <= data_rd_w;
            dmrs_rd_en_q <= dmrs_rd_w;
            sym_done_q   <= sym_done_w;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.data_rd_en_o = data_rd_en_q;
  assign bus.dmrs_rd_en_o = dmrs_rd_en_q;
  assign bus.sel_o        = sel_q;
  assign bus.grid_valid_o = grid_valid_q;
  assign bus.sc_idx_o     = sc_idx_q;
  assign bus.sym_idx_o    = sym_idx_q;
  assign bus.sym_done_o   = sym_done_q;
  assign bus.slot_done_o  = slot_done_q;
  assign bus.cfg_err_o    = cfg_err_q;
  assign bus.busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pusch_re_map_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pusch_re_map_scheduler: randomized slots checked cycle by cycle against a timeline model.
// Revision 1.0
// ============================================================================
module tb_pusch_re_map_scheduler;

  localparam int NFFT     = 32;
  localparam int SC_W     = 5;
  localparam int DMRS_SYM = 2;

  typedef struct packed {
    logic            busy;
    logic            cfg;
    logic            slot;
    logic            symd;
    logic [3:0]      sym;
    logic [SC_W-1:0] sc;
    logic            valid;
    logic [1:0]      sel;
    logic            mrd;
    logic            drd;
  } obs_t;

  typedef struct packed {
    logic        start;
    logic        da;
    logic        dr;
    logic        ir;
    logic [3:0]  ns;
    logic [6:0]  nrb;
    logic [10:0] nsc;
  } drv_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pusch_re_map_scheduler_if #(.SC_W(SC_W)) bus ();

  pusch_re_map_scheduler #(
    .NFFT    (NFFT),
    .SC_W    (SC_W),
    .DMRS_SYM(DMRS_SYM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];
  drv_t drv_q[$];
  int   mark_cyc;
  int   exp_reads;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // With mask set, index fields that carry no meaning (sc off-grid, sym when idle) read as 0.
  function automatic obs_t sample_dut(input bit mask);
    obs_t o;
    o.busy  = bus.busy_o;
    o.cfg   = bus.cfg_err_o;
    o.slot  = bus.slot_done_o;
    o.symd  = bus.sym_done_o;
    o.sym   = bus.sym_idx_o;
    o.sc    = bus.sc_idx_o;
    o.valid = bus.grid_valid_o;
    o.sel   = bus.sel_o;
    o.mrd   = bus.dmrs_rd_en_o;
    o.drd   = bus.data_rd_en_o;
    if (mask && !o.valid) o.sc = '0;
    if (mask && !o.busy) o.sym = '0;
    return o;
  endfunction

  function automatic drv_t idle_drv();
    drv_t d;
    d.start = 1'b0;
    d.da    = 1'($urandom);
    d.dr    = 1'($urandom);
    d.ir    = 1'($urandom);
    d.ns    = 4'($urandom);
    d.nrb   = 7'($urandom);
    d.nsc   = 11'($urandom);
    return d;
  endfunction

  task automatic drive(input drv_t d);
    bus.start_i      = d.start;
    bus.n_symbol_i   = d.ns;
    bus.n_rb_i       = d.nrb;
    bus.n_sc_i       = d.nsc;
    bus.data_avail_i = d.da;
    bus.dmrs_ready_i = d.dr;
    bus.ifft_ready_i = d.ir;
  endtask

  // Builds the expected per-cycle outputs and the per-cycle stimulus of one slot.
  // st_mode: 0 no stalls, 1 random stalls, 2 st_len stall before symbol 1 (st_kind 0 source, 1 ifft).
  task automatic build_slot(input int ns, input int nrb, input int nsc,
                            input int st_mode, input int st_len, input int st_kind);
    obs_t e;
    drv_t d;
    bit   ok, dm, inb;
    int   hi, s, kind;
    exp_q.delete();
    drv_q.delete();
    mark_cyc  = -1;
    exp_reads = 0;
    hi = nsc + 12 * nrb;
    ok = (ns != 0) && (nrb != 0) && (hi <= NFFT);
    e = '0;
    d = idle_drv();
    d.start = 1'b1; d.ns = 4'(ns); d.nrb = 7'(nrb); d.nsc = 11'(nsc);
    exp_q.push_back(e); drv_q.push_back(d);
    if (!ok) begin
      e = '0; e.cfg = 1'b1;
      exp_q.push_back(e); drv_q.push_back(idle_drv());
      e = '0;
      exp_q.push_back(e); drv_q.push_back(idle_drv());
      return;
    end
    for (int sym = 0; sym < ns; sym++) begin
      dm = (sym == DMRS_SYM);
      s = 0; kind = 0;
      if (st_mode == 1) begin
        s = $urandom_range(0, 4); kind = $urandom_range(0, 1);
      end else if (st_mode == 2 && sym == 1) begin
        s = st_len; kind = st_kind;
      end
      for (int w = 0; w <= s; w++) begin
        e = '0; e.busy = 1'b1; e.sym = 4'(sym);
        d = idle_drv();
        d.start = ($urandom_range(0, 7) == 0);
        if (w < s) begin
          if (kind == 0) begin
            if (dm) d.dr = 1'b0; else d.da = 1'b0;
          end else begin
            d.ir = 1'b0;
          end
        end else begin
          d.ir = 1'b1;
          if (dm) d.dr = 1'b1; else d.da = 1'b1;
        end
        exp_q.push_back(e); drv_q.push_back(d);
      end
      for (int k = 0; k < NFFT; k++) begin
        inb = (k >= nsc) && (k < hi);
        e = '0; e.busy = 1'b1; e.sym = 4'(sym); e.valid = 1'b1; e.sc = SC_W'(k);
        e.symd = (k == NFFT - 1);
        if (inb) begin
          exp_reads++;
          if (dm) begin e.sel = 2'd2; e.mrd = 1'b1; end
          else    begin e.sel = 2'd1; e.drd = 1'b1; end
        end
        d = idle_drv();
        d.start = ($urandom_range(0, 7) == 0);
        if (sym == 1 && k == 10) mark_cyc = exp_q.size();
        exp_q.push_back(e); drv_q.push_back(d);
      end
    end
    e = '0; e.busy = 1'b1; e.slot = 1'b1; e.sym = 4'(ns - 1);
    d = idle_drv();
    d.start = 1'($urandom_range(0, 1)); d.ns = 4'd3; d.nrb = 7'd1; d.nsc = 11'd0;
    exp_q.push_back(e); drv_q.push_back(d);
    e = '0;
    exp_q.push_back(e); drv_q.push_back(idle_drv());
  endtask

  task automatic run_timeline(input int abort_at, input string name);
    obs_t o;
    drv_t d;
    int   reads;
    reads = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = sample_dut(1'b1);
      check_eq($sformatf("%s cyc%0d", name, i), 32'(o), 32'(exp_q[i]));
      reads += int'(o.drd) + int'(o.mrd);
      drive(drv_q[i]);
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_eq({name, " async reset"}, 32'(sample_dut(1'b0)), 32'd0);
        d = idle_drv(); d.start = 1'b1; d.ns = 4'd3; d.nrb = 7'd1; d.nsc = 11'd4;
        drive(d);
        @(negedge clk);
        check_eq({name, " held reset"}, 32'(sample_dut(1'b0)), 32'd0);
        rst_n = 1'b1;
        d.start = 1'b0;
        drive(d);
        return;
      end
    end
    check_eq({name, " reads"}, 32'(reads), 32'(exp_reads));
  endtask

  initial begin
    drv_t d;
    int   ns, nrb, nsc;
    drive('0);
    #1 rst_n = 1'b0;
    d = idle_drv(); d.start = 1'b1; d.ns = 4'd3; d.nrb = 7'd1; d.nsc = 11'd4;
    d.da = 1'b1; d.dr = 1'b1; d.ir = 1'b1;
    drive(d);
    repeat (3) begin
      @(negedge clk);
      check_eq("reset hold", 32'(sample_dut(1'b0)), 32'd0);
    end
    rst_n = 1'b1;
    d.start = 1'b0;
    drive(d);
    repeat (3) begin
      @(negedge clk);
      check_eq("post reset idle", 32'(sample_dut(1'b0)), 32'd0);
    end

    build_slot(3, 1, 4, 0, 0, 0);   run_timeline(-1, "nominal");
    build_slot(3, 1, 4, 2, 10, 0);  run_timeline(-1, "stall data");
    build_slot(3, 1, 4, 2, 10, 1);  run_timeline(-1, "stall ifft");
    build_slot(4, 1, 4, 1, 0, 0);   run_timeline(-1, "stall random");
    build_slot(3, 1, 25, 0, 0, 0);  run_timeline(-1, "cfg band");
    build_slot(0, 1, 4, 0, 0, 0);   run_timeline(-1, "cfg nsym0");
    build_slot(3, 0, 4, 0, 0, 0);   run_timeline(-1, "cfg nrb0");
    build_slot(3, 1, 20, 0, 0, 0);  run_timeline(-1, "exact fit");
    build_slot(2, 2, 3, 1, 0, 0);   run_timeline(-1, "no dmrs");
    build_slot(14, 2, 0, 1, 0, 0);  run_timeline(-1, "full slot");
    build_slot(3, 1, 4, 0, 0, 0);   run_timeline(mark_cyc, "reset mid-MAP");
    build_slot(3, 1, 4, 0, 0, 0);   run_timeline(-1, "after reset");

    for (int r = 0; r < 12; r++) begin
      ns  = $urandom_range(0, 14);
      nrb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 3);
      nsc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 31);
      build_slot(ns, nrb, nsc, 1, 0, 0);
      run_timeline(-1, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
